// File: rtl/control_pkg.sv
// Shared encodings for the instruction decoder: opcodes, field encodings and
// the packed bundle of control signals passed between decode and register stage.
package control_pkg;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0111;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_TYPEA = 4'b1111;

    localparam logic [2:0] JB_NONE = 3'b000;
    localparam logic [2:0] JB_BEQ  = 3'b001;
    localparam logic [2:0] JB_BLT  = 3'b010;
    localparam logic [2:0] JB_BGT  = 3'b011;
    localparam logic [2:0] JB_JMP  = 3'b100;
    localparam logic [2:0] JB_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] RW_NONE   = 2'b00;
    localparam logic [1:0] RW_SINGLE = 2'b01;
    localparam logic [1:0] RW_DUAL   = 2'b10;

    localparam logic [1:0] MD_NORMAL = 2'b00;
    localparam logic [1:0] MD_MUL    = 2'b01;
    localparam logic [1:0] MD_DIV    = 2'b10;
    localparam logic [1:0] MD_RSVD   = 2'b11;

    typedef struct packed {
        logic       aluBType;
        logic       aluSrc;
        logic       zeroExtendFlag;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic       storeByte;
        logic [1:0] aluControlOp;
        logic [1:0] regWrite;
        logic [2:0] jumpBranch;
    } ctrlBits_t;

    localparam ctrlBits_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode/multiDiv decode; anything not matched is a NOP.
module control_decode
    import control_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] multiDiv,
    output logic       aluBType,
    output logic       aluSrc,
    output logic       zeroExtendFlag,
    output logic       memRead,
    output logic       memToReg,
    output logic       memWrite,
    output logic       storeByte,
    output logic [1:0] aluControlOp,
    output logic [1:0] regWrite,
    output logic [2:0] jumpBranch
);

    ctrlBits_t dec;

    always_comb begin
        dec = CTRL_NOP;
        case (opcode)
            OP_TYPEA: begin
                dec.aluControlOp = ALU_FUNCT;
                // Multiply/divide also write the upper half into R0
                dec.regWrite = (multiDiv == MD_MUL || multiDiv == MD_DIV) ? RW_DUAL : RW_SINGLE;
            end
            OP_ANDI, OP_ORI: begin
                dec.aluBType       = 1'b1;
                dec.aluSrc         = 1'b1;
                dec.zeroExtendFlag = 1'b1;
                dec.aluControlOp   = ALU_LOGIC;
                dec.regWrite       = RW_SINGLE;
            end
            OP_LBU, OP_LW: begin
                dec.aluBType     = 1'b1;
                dec.aluSrc       = 1'b1;
                dec.memRead      = 1'b1;
                dec.memToReg     = 1'b1;
                dec.aluControlOp = ALU_ADD;
                dec.regWrite     = RW_SINGLE;
            end
            OP_SB, OP_SW: begin
                dec.aluBType     = 1'b1;
                dec.aluSrc       = 1'b1;
                dec.memWrite     = 1'b1;
                dec.storeByte    = (opcode == OP_SB);
                dec.aluControlOp = ALU_ADD;
            end
            OP_BEQ: begin
                dec.aluBType     = 1'b1;
                dec.aluControlOp = ALU_SUB;
                dec.jumpBranch   = JB_BEQ;
            end
            OP_BLT: begin
                dec.aluBType     = 1'b1;
                dec.aluControlOp = ALU_SUB;
                dec.jumpBranch   = JB_BLT;
            end
            OP_BGT: begin
                dec.aluBType     = 1'b1;
                dec.aluControlOp = ALU_SUB;
                dec.jumpBranch   = JB_BGT;
            end
            OP_JMP:  dec.jumpBranch = JB_JMP;
            OP_HALT: dec.jumpBranch = JB_HALT;
            default: dec = CTRL_NOP;
        endcase
    end

    assign aluBType       = dec.aluBType;
    assign aluSrc         = dec.aluSrc;
    assign zeroExtendFlag = dec.zeroExtendFlag;
    assign memRead        = dec.memRead;
    assign memToReg       = dec.memToReg;
    assign memWrite       = dec.memWrite;
    assign storeByte      = dec.storeByte;
    assign aluControlOp   = dec.aluControlOp;
    assign regWrite       = dec.regWrite;
    assign jumpBranch     = dec.jumpBranch;

endmodule

// File: rtl/control.sv
// Main control unit: combinational decode followed by one register stage,
// so every control output lags its opcode by exactly one clock.
module control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic [1:0] multiDiv,
    output logic       aluBType,
    output logic       aluSrc,
    output logic       zeroExtendFlag,
    output logic       memRead,
    output logic       memToReg,
    output logic       memWrite,
    output logic       storeByte,
    output logic [1:0] aluControlOp,
    output logic [1:0] regWrite,
    output logic [2:0] jumpBranch
);

    ctrlBits_t nextCtrl;
    ctrlBits_t ctrlQ;

    control_decode uDecode (
        .opcode         (opcode),
        .multiDiv       (multiDiv),
        .aluBType       (nextCtrl.aluBType),
        .aluSrc         (nextCtrl.aluSrc),
        .zeroExtendFlag (nextCtrl.zeroExtendFlag),
        .memRead        (nextCtrl.memRead),
        .memToReg       (nextCtrl.memToReg),
        .memWrite       (nextCtrl.memWrite),
        .storeByte      (nextCtrl.storeByte),
        .aluControlOp   (nextCtrl.aluControlOp),
        .regWrite       (nextCtrl.regWrite),
        .jumpBranch     (nextCtrl.jumpBranch)
    );

    // Reset forces a NOP onto the outputs without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrlQ <= CTRL_NOP;
        else        ctrlQ <= nextCtrl;
    end

    assign aluBType       = ctrlQ.aluBType;
    assign aluSrc         = ctrlQ.aluSrc;
    assign zeroExtendFlag = ctrlQ.zeroExtendFlag;
    assign memRead        = ctrlQ.memRead;
    assign memToReg       = ctrlQ.memToReg;
    assign memWrite       = ctrlQ.memWrite;
    assign storeByte      = ctrlQ.storeByte;
    assign aluControlOp   = ctrlQ.aluControlOp;
    assign regWrite       = ctrlQ.regWrite;
    assign jumpBranch     = ctrlQ.jumpBranch;

endmodule

// File: tb/tb_control.sv
// Directed bench for the control unit: expected decodes go through a
// scoreboard queue and are compared one clock after the opcode is driven.
module tb_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic [1:0] multiDiv;
    logic       aluBType, aluSrc, zeroExtendFlag, memRead, memToReg;
    logic       memWrite, storeByte;
    logic [1:0] aluControlOp, regWrite;
    logic [2:0] jumpBranch;

    int checks = 0;
    int failures = 0;
    logic [13:0] sbq[$];
    logic [13:0] lastExp;

    control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .multiDiv(multiDiv),
        .aluBType(aluBType), .aluSrc(aluSrc), .zeroExtendFlag(zeroExtendFlag),
        .memRead(memRead), .memToReg(memToReg), .memWrite(memWrite),
        .storeByte(storeByte), .aluControlOp(aluControlOp),
        .regWrite(regWrite), .jumpBranch(jumpBranch)
    );

    always #5 clk = ~clk;

    // {bType, src, zext, memRd, memToReg, memWr, sByte, aluOp[2], regWr[2], jb[3]}
    function automatic logic [13:0] model(input logic [3:0] op, input logic [1:0] md);
        logic [13:0] e;
        case (op)
            4'b0000: e = 14'b0000000_00_00_111;
            4'b0001: e = 14'b1110000_11_01_000;
            4'b0010: e = 14'b1110000_11_01_000;
            4'b0100: e = 14'b1000000_01_00_011;
            4'b0101: e = 14'b1000000_01_00_010;
            4'b0110: e = 14'b1000000_01_00_001;
            4'b0111: e = 14'b0000000_00_00_100;
            4'b1010: e = 14'b1101100_00_01_000;
            4'b1011: e = 14'b1100011_00_00_000;
            4'b1100: e = 14'b1101100_00_01_000;
            4'b1101: e = 14'b1100010_00_00_000;
            4'b1111: e = (md == 2'b01 || md == 2'b10) ? 14'b0000000_10_10_000
                                                      : 14'b0000000_10_01_000;
            default: e = 14'b0;
        endcase
        return e;
    endfunction

    function automatic logic [13:0] observed();
        return {aluBType, aluSrc, zeroExtendFlag, memRead, memToReg, memWrite,
                storeByte, aluControlOp, regWrite, jumpBranch};
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkInvariants(input string tag);
        logic ok;
        ok = !(memRead && memWrite) &&
             !((memWrite || jumpBranch != 3'b000) && regWrite != 2'b00);
        check({tag, "_inv"}, {13'b0, ok}, 14'd1);
    endtask

    // Called at posedge+1: drive, confirm outputs hold, then compare after the edge
    task automatic step(input logic [3:0] op, input logic [1:0] md, input string tag);
        opcode   = op;
        multiDiv = md;
        sbq.push_back(model(op, md));
        #1;
        check({tag, "_hold"}, observed(), lastExp);
        @(posedge clk);
        #1;
        lastExp = sbq.pop_front();
        check(tag, observed(), lastExp);
        checkInvariants(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; opcode = 4'b1111; multiDiv = 2'b00;
        #1 rst_n = 1'b0;
        #1 check("reset_async", observed(), 14'b0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", observed(), 14'b0);
        lastExp = 14'b0;

        // Release mid-cycle; first edge loads the Type-A decode
        rst_n = 1'b1;
        sbq.push_back(model(4'b1111, 2'b00));
        @(posedge clk); #1;
        lastExp = sbq.pop_front();
        check("release_typeA", observed(), lastExp);
        check("release_typeA_direct", {aluControlOp, regWrite}, 4'b10_01);

        step(4'b1111, 2'b01, "typeA_mul");
        check("typeA_mul_rw", {12'b0, regWrite}, 14'd2);
        step(4'b1111, 2'b10, "typeA_div");
        step(4'b1111, 2'b11, "typeA_rsvd");
        check("typeA_rsvd_rw", {12'b0, regWrite}, 14'd1);
        step(4'b0001, 2'b01, "andi_md");
        check("andi_md_rw", {12'b0, regWrite}, 14'd1);

        step(4'b0001, 2'b00, "andi");
        step(4'b0010, 2'b00, "ori");
        step(4'b1010, 2'b00, "lbu");
        step(4'b1011, 2'b00, "sb");
        check("sb_direct", {12'b0, memWrite, storeByte}, 14'b11);
        step(4'b1100, 2'b00, "lw");
        step(4'b1101, 2'b00, "sw");

        step(4'b0101, 2'b00, "blt");
        step(4'b0100, 2'b00, "bgt");
        step(4'b0110, 2'b00, "beq");
        step(4'b0111, 2'b00, "jmp");
        step(4'b0000, 2'b00, "halt");
        check("halt_direct", {11'b0, jumpBranch}, 14'b111);

        for (int op = 0; op < 16; op++)
            for (int md = 0; md < 4; md++)
                step(op[3:0], md[1:0], $sformatf("sweep_%0d_%0d", op, md));

        // Mid-stream async reset with LW in flight
        step(4'b1100, 2'b00, "lw_pre_reset");
        #2 rst_n = 1'b0;
        #1 check("mid_reset_async", observed(), 14'b0);
        @(posedge clk); #1 check("mid_reset_hold", observed(), 14'b0);
        rst_n = 1'b1;
        #1 check("mid_release_noedge", observed(), 14'b0);
        @(posedge clk); #1;
        check("mid_release_lw", observed(), model(4'b1100, 2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameters: none; all encodings are fixed constants.
REQ-002 clk  input  1  rising-edge clock for the output register stage.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  4  instruction opcode field.
REQ-005 multiDiv  input  2  Type-A function class: 00 normal, 01 multiply, 10 divide, 11 reserved (treated as 00).
REQ-006 aluBType  output  1  1 = Type-B format; register-port mapping follows the Type-B layout.
REQ-007 aluSrc  output  1  1 = ALU B operand is the extended immediate.
REQ-008 zeroExtendFlag  output  1  1 = zero-extend immediate, 0 = sign-extend.
REQ-009 memRead  output  1  data-memory read enable.
REQ-010 memToReg  output  1  1 = write-back data comes from memory.
REQ-011 memWrite  output  1  data-memory write enable.
REQ-012 storeByte  output  1  1 = store writes the low byte only.
REQ-013 aluControlOp  output  2  00 add, 01 subtract/compare, 10 function-field driven, 11 opcode-driven logical.
REQ-014 regWrite  output  2  00 none, 01 single destination, 10 dual destination (multiply/divide writes result and R0).
REQ-015 jumpBranch  output  3  000 none, 001 BEQ, 010 BLT, 011 BGT, 100 JMP, 111 HALT.

Function
REQ-016 Decode is combinational from opcode/multiDiv; all outputs are registered on rising clk, giving exactly one cycle of latency.
REQ-017 Every output not listed for an opcode below is 0.
REQ-018 1111 Type-A: aluControlOp=10; regWrite=10 when multiDiv is 01 or 10, else 01.
REQ-019 0001 ANDI and 0010 ORI: aluBType=1, aluSrc=1, zeroExtendFlag=1, aluControlOp=11, regWrite=01.
REQ-020 1010 LBU: aluBType=1, aluSrc=1, memRead=1, memToReg=1, aluControlOp=00, regWrite=01.
REQ-021 1011 SB: aluBType=1, aluSrc=1, memWrite=1, storeByte=1, aluControlOp=00.
REQ-022 1100 LW: same as LBU.
REQ-023 1101 SW: aluBType=1, aluSrc=1, memWrite=1, storeByte=0, aluControlOp=00.
REQ-024 0110 BEQ / 0101 BLT / 0100 BGT: aluBType=1, aluControlOp=01, jumpBranch=001/010/011, regWrite=00.
REQ-025 0111 JMP: jumpBranch=100; 0000 HALT: jumpBranch=111; all other outputs 0.
REQ-026 Unused opcodes (0011, 1000, 1001, 1110) decode as NOP: every output 0.
REQ-027 multiDiv is ignored for every opcode other than 1111.
REQ-028 memRead and memWrite are never both 1; regWrite is 00 whenever memWrite=1 or jumpBranch!=000.

Reset
REQ-029 While rst_n=0, all outputs are 0 (NOP) immediately, independent of clk.
REQ-030 On rst_n release, the first rising clk edge loads the decode of the current opcode.

Structure
REQ-031 A shared package holds the opcode constants, the jumpBranch, aluControlOp and regWrite encodings, and the multiDiv class constants.
REQ-032 Implementation is one combinational sub-module, control_decode, plus the output register stage in control.

Verification
REQ-033 rst_n=0, opcode=1111 -> all outputs 0 without a clock edge; release, one edge -> aluControlOp=10, regWrite=01.
REQ-034 opcode=1111: multiDiv=01 -> regWrite=10 after one edge; multiDiv=11 -> regWrite=01; opcode=0001 with multiDiv=01 -> regWrite=01.
REQ-035 Sweep 0001, 0010, 1010, 1011, 1100, 1101 -> exact tables per REQ-019 to REQ-023; 1011 gives memWrite=1, storeByte=1.
REQ-036 Sweep 0101, 0100, 0110, 0111, 0000 -> jumpBranch 010, 011, 001, 100, 111; regWrite=00 in each case.
REQ-037 All 16 opcodes x 4 multiDiv values -> REQ-028 invariants hold; unused opcodes give all 0; each output changes exactly one edge after its input changes.
REQ-038 Assert rst_n mid-stream with opcode=1100 -> outputs drop to 0 asynchronously and stay 0 until the first edge after release.
